// File: rtl/bloom_lookup_arbiter.sv
// Round-robin arbiter sharing one Bloom filter lookup engine among NUM_PORTS.
// Optional WAIT abort is compiled in with `define BLOOM_ARB_TIMEOUT_EN.
module bloom_lookup_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int PW            = $clog2(NUM_PORTS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_PORTS-1:0]    req_valid,
  output logic [NUM_PORTS-1:0]    req_ready,
  input  logic [NUM_PORTS*32-1:0] req_src_ip,
  input  logic [NUM_PORTS*32-1:0] req_dest_ip,
  input  logic [NUM_PORTS*16-1:0] req_tag,
  output logic                    bf_enable,
  output logic [31:0]             bf_src_ip,
  output logic [31:0]             bf_dest_ip,
  output logic [15:0]             bf_tag,
  input  logic                    bf_busy,
  input  logic                    bf_output_valid,
  input  logic                    bf_safe,
  input  logic [63:0]             bf_header,
  input  logic [15:0]             bf_out_tag,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [PW-1:0]           rsp_port,
  output logic                    rsp_safe,
  output logic                    rsp_timeout,
  output logic [63:0]             rsp_header,
  output logic [15:0]             rsp_tag,
  output logic [31:0]             hit_count,
  output logic [31:0]             lookup_count
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] last_ptr_q;
  logic [PW-1:0] port_q;
  logic [15:0]   seq_q;
  logic [31:0]   src_q, dst_q;
  logic [15:0]   tag_q;
  logic          safe_q;
  logic [63:0]   hdr_q;
  logic [31:0]   hit_q, lkp_q;

  logic          gnt_hit;
  logic [PW-1:0] gnt_idx;
  logic [31:0]   sel_src, sel_dst;
  logic [15:0]   sel_tag;
  logic          match;
  logic          tmo_hit;

  // Scan strictly after last_ptr with wrap-around; first requester wins.
  always_comb begin
    int unsigned j;
    j       = 0;
    gnt_hit = 1'b0;
    gnt_idx = '0;
    sel_src = '0;
    sel_dst = '0;
    sel_tag = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      j = (int'(last_ptr_q) + i) % NUM_PORTS;
      if (!gnt_hit && req_valid[j]) begin
        gnt_hit = 1'b1;
        gnt_idx = PW'(j);
        sel_src = req_src_ip[32*j +: 32];
        sel_dst = req_dest_ip[32*j +: 32];
        sel_tag = req_tag[16*j +: 16];
      end
    end
  end

  assign match = bf_output_valid && (bf_out_tag == seq_q);

`ifdef BLOOM_ARB_TIMEOUT_EN
  logic [15:0] tcnt_q;
  logic        tmo_q;
  assign tmo_hit     = (tcnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign rsp_timeout = tmo_q;
`else
  assign tmo_hit     = (TIMEOUT_CYCLES == 0);
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    bf_enable = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_hit) begin
          req_ready[gnt_idx] = 1'b1;
          state_d            = ISSUE;
        end
      end
      ISSUE: begin
        if (!bf_busy) begin
          bf_enable = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (match || tmo_hit) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_ptr_q <= PW'(NUM_PORTS - 1);
      port_q     <= '0;
      seq_q      <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      tag_q      <= '0;
      safe_q     <= 1'b0;
      hdr_q      <= '0;
      hit_q      <= '0;
      lkp_q      <= '0;
`ifdef BLOOM_ARB_TIMEOUT_EN
      tcnt_q     <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (gnt_hit) begin
            last_ptr_q <= gnt_idx;
            port_q     <= gnt_idx;
            src_q      <= sel_src;
            dst_q      <= sel_dst;
            tag_q      <= sel_tag;
          end
        end
        ISSUE: begin
          if (!bf_busy) begin
            lkp_q <= lkp_q + 32'd1;
`ifdef BLOOM_ARB_TIMEOUT_EN
            tcnt_q <= '0;
`endif
          end
        end
        WAIT: begin
          if (match) begin
            safe_q <= bf_safe;
            hdr_q  <= bf_header;
            seq_q  <= seq_q + 16'd1;
            if (bf_safe) hit_q <= hit_q + 32'd1;
`ifdef BLOOM_ARB_TIMEOUT_EN
            tmo_q  <= 1'b0;
`endif
          end
`ifdef BLOOM_ARB_TIMEOUT_EN
          else if (tmo_hit) begin
            safe_q <= 1'b0;
            hdr_q  <= {src_q, dst_q};
            seq_q  <= seq_q + 16'd1;
            tmo_q  <= 1'b1;
          end
          tcnt_q <= tcnt_q + 16'd1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bf_src_ip    = src_q;
  assign bf_dest_ip   = dst_q;
  assign bf_tag       = seq_q;
  assign rsp_valid    = (state_q == RESP);
  assign rsp_port     = port_q;
  assign rsp_safe     = safe_q;
  assign rsp_header   = hdr_q;
  assign rsp_tag      = tag_q;
  assign hit_count    = hit_q;
  assign lookup_count = lkp_q;

endmodule

// File: tb/tb_bloom_lookup_arbiter.sv
// Directed bench for bloom_lookup_arbiter with a 5-cycle Bloom filter model.
// Timeout steps run only when BLOOM_ARB_TIMEOUT_EN is defined.
module tb_bloom_lookup_arbiter;
  localparam int NP = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NP-1:0]    req_valid, req_ready;
  logic [NP*32-1:0] req_src_ip, req_dest_ip;
  logic [NP*16-1:0] req_tag;
  logic             bf_enable;
  logic [31:0]      bf_src_ip, bf_dest_ip;
  logic [15:0]      bf_tag;
  logic             bf_busy, bf_output_valid, bf_safe;
  logic [63:0]      bf_header;
  logic [15:0]      bf_out_tag;
  logic             rsp_valid, rsp_ready;
  logic [1:0]       rsp_port;
  logic             rsp_safe, rsp_timeout;
  logic [63:0]      rsp_header;
  logic [15:0]      rsp_tag;
  logic [31:0]      hit_count, lookup_count;

  bloom_lookup_arbiter #(.NUM_PORTS(NP), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src_ip(req_src_ip), .req_dest_ip(req_dest_ip), .req_tag(req_tag),
    .bf_enable(bf_enable), .bf_src_ip(bf_src_ip), .bf_dest_ip(bf_dest_ip),
    .bf_tag(bf_tag), .bf_busy(bf_busy), .bf_output_valid(bf_output_valid),
    .bf_safe(bf_safe), .bf_header(bf_header), .bf_out_tag(bf_out_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_port(rsp_port),
    .rsp_safe(rsp_safe), .rsp_timeout(rsp_timeout), .rsp_header(rsp_header),
    .rsp_tag(rsp_tag), .hit_count(hit_count), .lookup_count(lookup_count)
  );

  // Filter model: result 5 cycles after enable, safe if key seen before.
  logic [4:0]  pipe = '0;
  logic [15:0] m_tag = '0;
  logic [63:0] m_hdr = '0;
  logic        m_safe = 1'b0;
  logic        dead, inj_valid;
  logic [15:0] inj_tag;
  logic [63:0] hist [8];
  logic [7:0]  hv = '0;
  logic [2:0]  hptr = '0;

  function automatic logic seen_key(input logic [63:0] k);
    for (int i = 0; i < 8; i++)
      if (hv[i] && hist[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      pipe <= '0;
    end else begin
      pipe <= {pipe[3:0], bf_enable & ~dead};
      if (bf_enable) begin
        m_tag      <= bf_tag;
        m_hdr      <= {bf_src_ip, bf_dest_ip};
        m_safe     <= seen_key({bf_src_ip, bf_dest_ip});
        hist[hptr] <= {bf_src_ip, bf_dest_ip};
        hv[hptr]   <= 1'b1;
        hptr       <= hptr + 3'd1;
      end
    end
  end

  assign bf_busy         = |pipe[3:0];
  assign bf_output_valid = pipe[4] | inj_valid;
  assign bf_out_tag      = inj_valid ? inj_tag : m_tag;
  assign bf_safe         = m_safe;
  assign bf_header       = m_hdr;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [31:0] s,
                          input logic [31:0] d, input logic [15:0] t);
    req_src_ip[32*p +: 32]  = s;
    req_dest_ip[32*p +: 32] = d;
    req_tag[16*p +: 16]     = t;
  endtask

  int unsigned rr_exp [6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    rst_n = 1'b0; req_valid = '0; req_src_ip = '0; req_dest_ip = '0;
    req_tag = '0; rsp_ready = 1'b1; dead = 1'b0;
    inj_valid = 1'b0; inj_tag = '0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_bf_enable", 64'(bf_enable), 64'h0);
    chk("rst_bf_tag", 64'(bf_tag), 64'h0);
    chk("rst_bf_src", 64'(bf_src_ip), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_header", rsp_header, 64'h0);
    chk("rst_counts", {hit_count, lookup_count}, 64'h0);
    chk("rst_rsp_timeout", 64'(rsp_timeout), 64'h0);

    // single request from port 2
    set_port(2, 32'h0A000001, 32'h0A000002, 16'h00AB);
    req_valid = 4'b0100;
    #1 chk("t1_grant", 64'(req_ready), 64'h4);
    tick();
    req_valid = '0;
    #1 chk("t1_bf_enable", 64'(bf_enable), 64'h1);
    chk("t1_bf_tag", 64'(bf_tag), 64'h0);
    chk("t1_bf_ips", {bf_src_ip, bf_dest_ip}, 64'h0A0000010A000002);
    repeat (5) tick();
    chk("t1_no_rsp_t6", 64'(rsp_valid), 64'h0);
    tick();
    chk("t1_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("t1_rsp_port", 64'(rsp_port), 64'h2);
    chk("t1_rsp_safe", 64'(rsp_safe), 64'h0);
    chk("t1_rsp_tag", 64'(rsp_tag), 64'h00AB);
    chk("t1_rsp_header", rsp_header, 64'h0A0000010A000002);
    chk("t1_rsp_timeout", 64'(rsp_timeout), 64'h0);
    chk("t1_counts", {hit_count, lookup_count}, {32'd0, 32'd1});
    tick();

    // repeat lookup of same IPs from port 0
    set_port(0, 32'h0A000001, 32'h0A000002, 16'h1234);
    req_valid = 4'b0001;
    #1 chk("t2_grant", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    #1 chk("t2_bf_tag", 64'(bf_tag), 64'h1);
    repeat (6) tick();
    chk("t2_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("t2_rsp_port", 64'(rsp_port), 64'h0);
    chk("t2_rsp_safe", 64'(rsp_safe), 64'h1);
    chk("t2_rsp_tag", 64'(rsp_tag), 64'h1234);
    chk("t2_counts", {hit_count, lookup_count}, {32'd1, 32'd2});
    tick();

    // response backpressure on port 1
    set_port(1, 32'h0A000003, 32'h0A000004, 16'h0055);
    req_valid = 4'b0010;
    #1 chk("t3_grant", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    rsp_ready = 1'b0;
    #1 chk("t3_bf_tag", 64'(bf_tag), 64'h2);
    repeat (6) tick();
    set_port(3, 32'h0A000005, 32'h0A000006, 16'h0777);
    req_valid = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t3_hold_valid", 64'(rsp_valid), 64'h1);
      chk("t3_hold_header", rsp_header, 64'h0A0000030A000004);
      chk("t3_hold_meta", {rsp_tag, 14'd0, rsp_port, 31'd0, rsp_safe},
          {16'h0055, 14'd0, 2'd1, 31'd0, 1'b0});
      chk("t3_no_grant", 64'(req_ready), 64'h0);
      chk("t3_no_enable", 64'(bf_enable), 64'h0);
      tick();
    end
    rsp_ready = 1'b1;
    #1 chk("t3_accept_no_grant", 64'(req_ready), 64'h0);
    tick();
    chk("t3_next_grant", 64'(req_ready), 64'h8);

    // port 3 lookup with a stray mismatched-tag strobe
    tick();
    req_valid = '0;
    #1 chk("t4_bf_tag", 64'(bf_tag), 64'h3);
    tick();
    tick();
    inj_valid = 1'b1;
    inj_tag   = 16'h0099;
    tick();
    inj_valid = 1'b0;
    #1 chk("t4_stray_dropped", 64'(rsp_valid), 64'h0);
    repeat (3) tick();
    chk("t4_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("t4_rsp_port", 64'(rsp_port), 64'h3);
    chk("t4_rsp_tag", 64'(rsp_tag), 64'h0777);
    chk("t4_counts", {hit_count, lookup_count}, {32'd1, 32'd4});
    tick();

    // reset in the middle of WAIT
    set_port(1, 32'h0A000007, 32'h0A000008, 16'h0101);
    req_valid = 4'b0010;
    #1 chk("t5_grant", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("t5_bf_enable", 64'(bf_enable), 64'h0);
    chk("t5_bf_tag", 64'(bf_tag), 64'h0);
    chk("t5_bf_ips", {bf_src_ip, bf_dest_ip}, 64'h0);
    chk("t5_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("t5_rsp_data", rsp_header, 64'h0);
    chk("t5_rsp_meta", {rsp_tag, rsp_port}, 64'h0);
    chk("t5_counts", {hit_count, lookup_count}, 64'h0);

    // round-robin with all ports requesting
    for (int p = 0; p < NP; p++)
      set_port(p, 32'h0B000000 + 32'(p), 32'h0B000100 + 32'(p),
               16'h0100 + 16'(p));
    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      #1 chk("rr_grant", 64'(req_ready), 64'(4'b0001 << rr_exp[i]));
      tick();
      chk("rr_bf_tag", 64'(bf_tag), 64'(i));
      repeat (6) tick();
      chk("rr_rsp_port", 64'(rsp_port), 64'(rr_exp[i]));
      chk("rr_rsp_tag", 64'(rsp_tag), 64'(16'h0100 + 16'(rr_exp[i])));
      if (i == 5) req_valid = '0;
      tick();
    end
    chk("rr_lookups", 64'(lookup_count), 64'd6);

`ifdef BLOOM_ARB_TIMEOUT_EN
    // filter never answers
    dead = 1'b1;
    set_port(2, 32'h0C000001, 32'h0C000002, 16'h0ABC);
    req_valid = 4'b0100;
    #1 chk("to_grant", 64'(req_ready), 64'h4);
    tick();
    req_valid = '0;
    #1 chk("to_bf_enable", 64'(bf_enable), 64'h1);
    chk("to_bf_tag", 64'(bf_tag), 64'h6);
    repeat (64) tick();
    chk("to_not_yet", 64'(rsp_valid), 64'h0);
    tick();
    chk("to_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("to_rsp_timeout", 64'(rsp_timeout), 64'h1);
    chk("to_rsp_safe", 64'(rsp_safe), 64'h0);
    chk("to_rsp_header", rsp_header, 64'h0C0000010C000002);
    tick();
    dead      = 1'b0;
    inj_valid = 1'b1;
    inj_tag   = 16'h0006;
    tick();
    inj_valid = 1'b0;
    #1 chk("to_late_dropped", 64'(rsp_valid), 64'h0);
    tick();
    chk("to_late_dropped2", 64'(rsp_valid), 64'h0);
    set_port(0, 32'h0C000003, 32'h0C000004, 16'h0DEF);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    #1 chk("to_next_tag", 64'(bf_tag), 64'h7);
    repeat (6) tick();
    chk("to_next_rsp", {63'd0, rsp_valid}, 64'h1);
    chk("to_next_clear", 64'(rsp_timeout), 64'h0);
    tick();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
